// File: rtl/strassen_mm2x2_pipe_pkg.sv
// Shared definitions for the Strassen 2x2 multiplier: FSM states, product indices
// and the round-count helper used to size the multiplier schedule.
package strassen_mm2x2_pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESUM,
    ST_MULT,
    ST_COMBINE,
    ST_DONE
  } state_t;

  localparam int NUM_PRODUCTS = 7;

  localparam int M1_IDX = 0;
  localparam int M2_IDX = 1;
  localparam int M3_IDX = 2;
  localparam int M4_IDX = 3;
  localparam int M5_IDX = 4;
  localparam int M6_IDX = 5;
  localparam int M7_IDX = 6;

  // Rounds needed to cover all seven products with the given number of lanes.
  function automatic int num_rounds(input int lanes);
    return (NUM_PRODUCTS + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/strassen_mm2x2_pipe_mult_lane.sv
// One shared multiplier lane: selects the operand pair for product number idx and
// multiplies it; indices of 7 and above select zeros (lane idle in that round).
module strassen_mult_lane
  import strassen_mm2x2_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        [3:0]         idx,
  input  logic signed [WIDTH:0]     opx [NUM_PRODUCTS],
  input  logic signed [WIDTH:0]     opy [NUM_PRODUCTS],
  output logic signed [2*WIDTH+1:0] prod
);

  localparam int PW = 2 * WIDTH + 2;

  logic signed [WIDTH:0] x;
  logic signed [WIDTH:0] y;

  always_comb begin
    x = '0;
    y = '0;
    if (idx < 4'd7) begin
      x = opx[idx[2:0]];
      y = opy[idx[2:0]];
    end
    prod = PW'(x) * PW'(y);
  end

endmodule

// File: rtl/strassen_mm2x2_pipe.sv
// Strassen 2x2 signed matrix multiplier on NUM_MULT shared lanes with valid/ready ports.
// Define STRASSEN_SAT_EN for WIDTH-bit saturated outputs plus a sat_flag port.
module strassen_mm2x2_pipe
  import strassen_mm2x2_pipe_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_MULT = 1,
  localparam int OUT_W   = 2 * WIDTH + 1,
`ifdef STRASSEN_SAT_EN
  localparam int CW      = WIDTH
`else
  localparam int CW      = OUT_W
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [WIDTH-1:0] a11,
  input  logic signed [WIDTH-1:0] a12,
  input  logic signed [WIDTH-1:0] a21,
  input  logic signed [WIDTH-1:0] a22,
  input  logic signed [WIDTH-1:0] b11,
  input  logic signed [WIDTH-1:0] b12,
  input  logic signed [WIDTH-1:0] b21,
  input  logic signed [WIDTH-1:0] b22,
`ifdef STRASSEN_SAT_EN
  output logic                 sat_flag,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [CW-1:0] c11,
  output logic signed [CW-1:0] c12,
  output logic signed [CW-1:0] c21,
  output logic signed [CW-1:0] c22
);

  localparam int R  = num_rounds(NUM_MULT);
  localparam int EW = WIDTH + 1;
  localparam int PW = 2 * WIDTH + 2;
  localparam int SW = 2 * WIDTH + 4;
  localparam logic [2:0] RND_LAST = 3'(R - 1);

  state_t state, state_nx;
  logic [2:0] rnd;

  logic signed [WIDTH-1:0] ra11, ra12, ra21, ra22, rb11, rb12, rb21, rb22;
  logic signed [EW-1:0] sa1122, sb1122, sa2122, sb1222, sb2111;
  logic signed [EW-1:0] sa1112, sa2111, sb1112, sa1222, sb2122;

  logic signed [EW-1:0] opx [NUM_PRODUCTS];
  logic signed [EW-1:0] opy [NUM_PRODUCTS];
  logic        [3:0]    lane_idx [NUM_MULT];
  logic signed [PW-1:0] lane_p [NUM_MULT];
  logic signed [PW-1:0] m [NUM_PRODUCTS];
  logic signed [SW-1:0] f11, f12, f21, f22;

  function automatic logic signed [SW-1:0] sx(input logic signed [PW-1:0] v);
    return {{(SW - PW){v[PW-1]}}, v};
  endfunction

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (in_valid) state_nx = ST_PRESUM;
      ST_PRESUM:  state_nx = ST_MULT;
      ST_MULT:    if (rnd == RND_LAST) state_nx = ST_COMBINE;
      ST_COMBINE: state_nx = ST_DONE;
      ST_DONE:    if (out_ready) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Operand pairs feeding the lanes, indexed by product number.
  always_comb begin
    opx[M1_IDX] = sa1122;                      opy[M1_IDX] = sb1122;
    opx[M2_IDX] = sa2122;                      opy[M2_IDX] = {rb11[WIDTH-1], rb11};
    opx[M3_IDX] = {ra11[WIDTH-1], ra11};       opy[M3_IDX] = sb1222;
    opx[M4_IDX] = {ra22[WIDTH-1], ra22};       opy[M4_IDX] = sb2111;
    opx[M5_IDX] = sa1112;                      opy[M5_IDX] = {rb22[WIDTH-1], rb22};
    opx[M6_IDX] = sa2111;                      opy[M6_IDX] = sb1112;
    opx[M7_IDX] = sa1222;                      opy[M7_IDX] = sb2122;
  end

  always_comb begin
    for (int j = 0; j < NUM_MULT; j++) lane_idx[j] = 4'(int'(rnd) * NUM_MULT + j);
  end

  for (genvar g = 0; g < NUM_MULT; g++) begin : g_lane
    strassen_mult_lane #(.WIDTH(WIDTH)) u_lane (
      .idx  (lane_idx[g]),
      .opx  (opx),
      .opy  (opy),
      .prod (lane_p[g])
    );
  end

  always_comb begin
    f11 = sx(m[M1_IDX]) + sx(m[M4_IDX]) - sx(m[M5_IDX]) + sx(m[M7_IDX]);
    f12 = sx(m[M3_IDX]) + sx(m[M5_IDX]);
    f21 = sx(m[M2_IDX]) + sx(m[M4_IDX]);
    f22 = sx(m[M1_IDX]) - sx(m[M2_IDX]) + sx(m[M3_IDX]) + sx(m[M6_IDX]);
  end

`ifdef STRASSEN_SAT_EN
  localparam logic signed [SW-1:0] SMAX = {{(SW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  logic sat_r;

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [SW-1:0] v);
    if (v > SMAX) return SMAX[WIDTH-1:0];
    if (v < SMIN) return SMIN[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  function automatic logic clipped(input logic signed [SW-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  assign sat_flag = sat_r & out_valid;
`endif

  // Datapath registers; each stage only writes the registers it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd  <= '0;
      ra11 <= '0; ra12 <= '0; ra21 <= '0; ra22 <= '0;
      rb11 <= '0; rb12 <= '0; rb21 <= '0; rb22 <= '0;
      sa1122 <= '0; sb1122 <= '0; sa2122 <= '0; sb1222 <= '0; sb2111 <= '0;
      sa1112 <= '0; sa2111 <= '0; sb1112 <= '0; sa1222 <= '0; sb2122 <= '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) m[i] <= '0;
      c11 <= '0; c12 <= '0; c21 <= '0; c22 <= '0;
`ifdef STRASSEN_SAT_EN
      sat_r <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          ra11 <= a11; ra12 <= a12; ra21 <= a21; ra22 <= a22;
          rb11 <= b11; rb12 <= b12; rb21 <= b21; rb22 <= b22;
        end
        ST_PRESUM: begin
          rnd    <= '0;
          sa1122 <= {ra11[WIDTH-1], ra11} + {ra22[WIDTH-1], ra22};
          sb1122 <= {rb11[WIDTH-1], rb11} + {rb22[WIDTH-1], rb22};
          sa2122 <= {ra21[WIDTH-1], ra21} + {ra22[WIDTH-1], ra22};
          sb1222 <= {rb12[WIDTH-1], rb12} - {rb22[WIDTH-1], rb22};
          sb2111 <= {rb21[WIDTH-1], rb21} - {rb11[WIDTH-1], rb11};
          sa1112 <= {ra11[WIDTH-1], ra11} + {ra12[WIDTH-1], ra12};
          sa2111 <= {ra21[WIDTH-1], ra21} - {ra11[WIDTH-1], ra11};
          sb1112 <= {rb11[WIDTH-1], rb11} + {rb12[WIDTH-1], rb12};
          sa1222 <= {ra12[WIDTH-1], ra12} - {ra22[WIDTH-1], ra22};
          sb2122 <= {rb21[WIDTH-1], rb21} + {rb22[WIDTH-1], rb22};
        end
        ST_MULT: begin
          rnd <= rnd + 3'd1;
          for (int j = 0; j < NUM_MULT; j++)
            if (lane_idx[j] < 4'd7) m[lane_idx[j][2:0]] <= lane_p[j];
        end
        ST_COMBINE: begin
`ifdef STRASSEN_SAT_EN
          c11 <= sat_w(f11); c12 <= sat_w(f12);
          c21 <= sat_w(f21); c22 <= sat_w(f22);
          sat_r <= clipped(f11) | clipped(f12) | clipped(f21) | clipped(f22);
`else
          c11 <= f11[OUT_W-1:0]; c12 <= f12[OUT_W-1:0];
          c21 <= f21[OUT_W-1:0]; c22 <= f22[OUT_W-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
